// File: rtl/seg7_pkg.sv
// Shared types, segment constants and helpers for the seven-segment display engine.
package seg7_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_LOAD_F = 2'd1;
  localparam fsm_state_t ST_SHIFT  = 2'd2;
  localparam fsm_state_t ST_COMMIT = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {dp,g,f,e,d,c,b,a}; non-decimal codes render dark.
  function automatic logic [7:0] seg_of(input logic [3:0] bcd);
    logic [7:0] pat;
    case (bcd)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; start loads a value, ready marks the final shift.
module bin2bcd_seq #(
  parameter int FIELD_W      = 7,
  parameter int FIELD_DIGITS = 2
) (
  input  logic                      clk_sys,
  input  logic                      rst_b,
  input  logic                      start,
  input  logic [FIELD_W-1:0]        bin,
  output logic                      ready,
  output logic [FIELD_DIGITS*4-1:0] result
);

  localparam int BCD_W = FIELD_DIGITS * 4;
  localparam int SR_W  = BCD_W + FIELD_W;
  localparam int CNT_W = $clog2(FIELD_W + 1);

  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_nxt;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    adj = sr_q[SR_W-1 -: BCD_W];
    for (int d = 0; d < FIELD_DIGITS; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
    end
    sr_nxt = {adj, sr_q[FIELD_W-1:0]} << 1;
  end

  // ready is high during the last shift; result is the value that shift produces.
  assign ready  = (cnt_q == CNT_W'(1));
  assign result = sr_nxt[SR_W-1 -: BCD_W];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sr_q  <= {{BCD_W{1'b0}}, bin};
      cnt_q <= CNT_W'(FIELD_W);
    end else if (cnt_q != '0) begin
      sr_q  <= sr_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/seg7_display_engine.sv
// Multi-field BCD display engine with load handshake, pending buffer and digit scan.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros within each field.
//
// state     | meaning
// ST_IDLE   | waiting for load
// ST_LOAD_F | seed converter with field f
// ST_SHIFT  | FIELD_W shift-add-3 steps, result to staging[f]
// ST_COMMIT | staging -> frame in one cycle, done pulse
module seg7_display_engine
  import seg7_pkg::*;
#(
  parameter int NUM_FIELDS   = 4,
  parameter int FIELD_DIGITS = 2,
  parameter int FIELD_W      = 7,
  parameter int SCAN_DIV     = 20000,
  localparam int NUM_DIGITS  = NUM_FIELDS * FIELD_DIGITS
) (
  input  logic                          clk100MHz,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NUM_FIELDS*FIELD_W-1:0] vals,
  input  logic [NUM_FIELDS-1:0]         blank,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_DIGITS-1:0]         LEDSEL,
  output logic [7:0]                    LEDOUT
);

  localparam int BCD_W  = FIELD_DIGITS * 4;
  localparam int FIDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [31:0] OVF_LIM = pow10(FIELD_DIGITS) - 32'd1;

  fsm_state_t                    state;
  logic [FIDX_W-1:0]             f_idx;
  logic [NUM_FIELDS*FIELD_W-1:0] cap_vals;
  logic [NUM_FIELDS*FIELD_W-1:0] pend_vals;
  logic [NUM_FIELDS-1:0]         cap_blank;
  logic [NUM_FIELDS-1:0]         pend_blank;
  logic                          pend_valid;
  logic [NUM_FIELDS-1:0]         cap_ovf;
  logic [BCD_W-1:0]              staging   [NUM_FIELDS];
  logic [BCD_W-1:0]              frame_bcd [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]         frame_blank;
  logic [NUM_FIELDS-1:0]         frame_ovf;
  logic                          bcd_start;
  logic                          bcd_ready;
  logic [BCD_W-1:0]              bcd_result;
  logic [FIELD_W-1:0]            field_val;
  logic [SCAN_W-1:0]             scan_cnt;
  logic [DIG_W-1:0]              dig_idx;
  logic [7:0]                    dig_pat [NUM_DIGITS];
  logic [3:0]                    nib;
  logic [7:0]                    pat;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                          lead;
`endif

  assign busy      = (state == ST_LOAD_F) || (state == ST_SHIFT);
  assign done      = (state == ST_COMMIT);
  assign bcd_start = (state == ST_LOAD_F);
  assign field_val = cap_vals[f_idx*FIELD_W +: FIELD_W];

  bin2bcd_seq #(
    .FIELD_W      (FIELD_W),
    .FIELD_DIGITS (FIELD_DIGITS)
  ) u_bin2bcd (
    .clk_sys (clk100MHz),
    .rst_b   (rst),
    .start   (bcd_start),
    .bin     (field_val),
    .ready   (bcd_ready),
    .result  (bcd_result)
  );

  always_comb begin
    for (int fi = 0; fi < NUM_FIELDS; fi++) begin
      cap_ovf[fi] = (32'(cap_vals[fi*FIELD_W +: FIELD_W]) > OVF_LIM);
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      f_idx      <= '0;
      cap_vals   <= '0;
      cap_blank  <= '0;
      pend_vals  <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            cap_vals  <= vals;
            cap_blank <= blank;
            f_idx     <= '0;
            state     <= ST_LOAD_F;
          end
        end
        ST_LOAD_F: state <= ST_SHIFT;
        ST_SHIFT: begin
          if (bcd_ready) begin
            if (f_idx == FIDX_W'(NUM_FIELDS - 1)) begin
              state <= ST_COMMIT;
            end else begin
              f_idx <= f_idx + 1'b1;
              state <= ST_LOAD_F;
            end
          end
        end
        ST_COMMIT: begin
          // A load arriving now is newer than anything pending, so it wins.
          if (load || pend_valid) begin
            cap_vals   <= load ? vals : pend_vals;
            cap_blank  <= load ? blank : pend_blank;
            pend_valid <= 1'b0;
            f_idx      <= '0;
            state      <= ST_LOAD_F;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (load && busy) begin
        pend_vals  <= vals;
        pend_blank <= blank;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        staging[i]   <= '0;
        frame_bcd[i] <= '0;
      end
      frame_blank <= '1;
      frame_ovf   <= '0;
    end else begin
      if (state == ST_SHIFT && bcd_ready) staging[f_idx] <= bcd_result;
      if (state == ST_COMMIT) begin
        frame_bcd   <= staging;
        frame_blank <= cap_blank;
        frame_ovf   <= cap_ovf;
      end
    end
  end

  // Blank beats overflow; leading-zero suppression never touches the ones digit.
  always_comb begin
    nib = 4'd0;
    pat = SEG_BLANK;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lead = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) dig_pat[i] = SEG_BLANK;
    for (int fi = 0; fi < NUM_FIELDS; fi++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lead = 1'b1;
`endif
      for (int k = FIELD_DIGITS - 1; k >= 0; k--) begin
        nib = frame_bcd[fi][k*4 +: 4];
        if (frame_blank[fi])    pat = SEG_BLANK;
        else if (frame_ovf[fi]) pat = SEG_DASH;
        else                    pat = seg_of(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead = lead && (nib == 4'd0);
        if (lead && (k != 0) && !frame_blank[fi] && !frame_ovf[fi]) pat = SEG_BLANK;
`endif
        dig_pat[fi*FIELD_DIGITS + k] = pat;
      end
    end
  end

  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      LEDSEL   <= '1;
      LEDOUT   <= '1;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      LEDSEL   <= ~(NUM_DIGITS'(1) << dig_idx);
      LEDOUT   <= dig_pat[dig_idx];
      dig_idx  <= (dig_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_display_engine.sv
// Scoreboard bench: stimulus queues expected done cycle and frame, monitor checks done and scanned digits.
module tb_seg7_display_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [27:0] vals;
  logic [3:0]  blank;
  logic        busy;
  logic        done;
  logic [7:0]  LEDSEL;
  logic [7:0]  LEDOUT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [63:0] pats;
  } exp_t;

  exp_t sb_q[$];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [63:0] P1 = 64'h90_90_99_A4_FF_F8_FF_C0;
  localparam logic [63:0] P2 = 64'h90_90_BF_BF_FF_F8_FF_C0;
  localparam logic [63:0] PA = 64'hFF_F9_FF_A4_FF_B0_FF_99;
  localparam logic [63:0] PC = 64'hBF_BF_F9_C0_82_92_FF_92;
`else
  localparam logic [63:0] P1 = 64'h90_90_99_A4_C0_F8_C0_C0;
  localparam logic [63:0] P2 = 64'h90_90_BF_BF_C0_F8_C0_C0;
  localparam logic [63:0] PA = 64'hC0_F9_C0_A4_C0_B0_C0_99;
  localparam logic [63:0] PC = 64'hBF_BF_F9_C0_82_92_C0_92;
`endif
  localparam logic [63:0] P3 = 64'hF9_A4_B0_99_92_82_FF_FF;

  seg7_display_engine #(
    .NUM_FIELDS   (4),
    .FIELD_DIGITS (2),
    .FIELD_W      (7),
    .SCAN_DIV     (4)
  ) dut (
    .clk100MHz (clk),
    .rst       (rst),
    .load      (load),
    .vals      (vals),
    .blank     (blank),
    .busy      (busy),
    .done      (done),
    .LEDSEL    (LEDSEL),
    .LEDOUT    (LEDOUT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  // Monitor: scan sequence, displayed frame and done pulses.
  logic [7:0]  prev_sel;
  logic [7:0]  sel_exp;
  logic [63:0] exp_cur = '1;
  logic [63:0] exp_new = '1;
  bit          promote = 1'b0;
  int          exp_idx = 0;
  int          last_chg = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ledsel", LEDSEL, 8'hFF);
      chk("rst_ledout", LEDOUT, 8'hFF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      exp_cur  = '1;
      exp_idx  = 0;
      promote  = 1'b0;
      sb_q.delete();
      prev_sel = 8'hFF;
      last_chg = cyc;
    end else begin
      if (LEDSEL !== prev_sel) begin
        sel_exp = ~(8'h01 << exp_idx);
        chk("scan_sel", LEDSEL, sel_exp);
        chk("scan_period", cyc - last_chg, 4);
        chk("scan_seg", LEDOUT, exp_cur[exp_idx*8 +: 8]);
        prev_sel = LEDSEL;
        last_chg = cyc;
        exp_idx  = (exp_idx + 1) % 8;
      end else begin
        chk("scan_stall", (cyc - last_chg) <= 4, 1'b1);
      end
      // Frame changes after the commit edge, so the new frame applies one sample later.
      if (promote) begin
        exp_cur = exp_new;
        promote = 1'b0;
      end
      if (done) begin
        chk("done_busy_low", busy, 1'b0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          exp_new = e.pats;
          promote = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [27:0] v, input logic [3:0] b, output int c);
    @(negedge clk);
    load  = 1'b1;
    vals  = v;
    blank = b;
    c     = cyc;
    @(negedge clk);
    load = 1'b0;
    chk("busy_after_load", busy, 1'b1);
  endtask

  task automatic expect_done(input int c, input logic [63:0] p);
    exp_t x;
    x.cyc  = 32'(c);
    x.pats = p;
    sb_q.push_back(x);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", n < bound, 1'b1);
  endtask

  int c0, c1;

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    vals  = '0;
    blank = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) @(negedge clk);

    issue({7'd99, 7'd42, 7'd7, 7'd0}, 4'b0000, c0);
    expect_done(c0 + 33, P1);
    wait_idle(100);
    repeat (40) @(negedge clk);

    issue({7'd99, 7'd100, 7'd7, 7'd0}, 4'b0000, c0);
    expect_done(c0 + 33, P2);
    wait_idle(100);
    repeat (40) @(negedge clk);

    issue({7'd12, 7'd34, 7'd56, 7'd100}, 4'b0001, c0);
    expect_done(c0 + 33, P3);
    wait_idle(100);
    repeat (40) @(negedge clk);

    // A at +0, B at +5, C at +10: B is overwritten, C follows A's commit.
    issue({7'd1, 7'd2, 7'd3, 7'd4}, 4'b0000, c0);
    expect_done(c0 + 33, PA);
    while (cyc < c0 + 4) @(negedge clk);
    issue({7'd88, 7'd88, 7'd88, 7'd88}, 4'b0000, c1);
    while (cyc < c0 + 9) @(negedge clk);
    issue({7'd127, 7'd10, 7'd65, 7'd5}, 4'b0000, c1);
    expect_done(c0 + 66, PC);
    wait_idle(150);
    repeat (40) @(negedge clk);

    // Reset in the middle of a conversion.
    issue({7'd11, 7'd22, 7'd33, 7'd44}, 4'b0000, c0);
    while (cyc < c0 + 10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ledsel", LEDSEL, 8'hFF);
    chk("async_rst_ledout", LEDOUT, 8'hFF);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (80) @(negedge clk);

    chk("queue_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
